// File: rtl/seq_lock.sv
// seq_lock: two-button sequence lock with failed-attempt lockout,
// inter-press timeout and automatic relock.
// Optional feature macro: SEQ_LOCK_PROG_EN. It adds a prog_in input and a
// PROG state that lets the code be changed while the lock is open.
module seq_lock #(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] CODE           = 5'b01011,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCKOUT_CYCLES = 1000,
  parameter int                  OPEN_CYCLES    = 500,
  parameter int                  TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b0_in,
  input  logic       b1_in,
`ifdef SEQ_LOCK_PROG_EN
  input  logic       prog_in,
`endif
  output logic       unlocked,
  output logic       locked_out,
  output logic [2:0] state_o,
  output logic [4:0] progress,
  output logic [3:0] fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_LOCKOUT = 3'd3,
    S_PROG    = 3'd4
  } state_t;

  localparam int CNT_W  = $clog2(CODE_LEN) + 1;
  localparam int FAIL_W = $clog2(MAX_FAIL) + 1;
  localparam int GAP_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int OPEN_W = $clog2(OPEN_CYCLES) + 1;
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES) + 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CODE_LEN);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [OPEN_W-1:0] OPEN_LAST = OPEN_W'(OPEN_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

  // Shift one digit into the low end of an entry word (first press ends up in the MSB).
  function automatic logic [CODE_LEN-1:0] shift_in(input logic [CODE_LEN-1:0] cur,
                                                   input logic                digit);
    logic [CODE_LEN-1:0] r;
    r    = cur << 1;
    r[0] = digit;
    return r;
  endfunction

  // Synchroniser chains: bit0 = first flop, bit1 = second flop, bit2 = edge-detect history.
  logic [2:0] b0_sync_q;
  logic [2:0] b1_sync_q;
  logic       b0_pulse_s;
  logic       b1_pulse_s;
  logic       press_s;
  logic       digit_s;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [FAIL_W-1:0]   fail_q;
  logic [GAP_W-1:0]    gap_q;
  logic [OPEN_W-1:0]   open_q;
  logic [LOCK_W-1:0]   lock_q;
  logic [CODE_LEN-1:0] entry_q;
  logic                unlocked_q;
  logic                locked_out_q;
  logic [CODE_LEN-1:0] active_code_s;

`ifdef SEQ_LOCK_PROG_EN
  logic [2:0]          prog_sync_q;
  logic                prog_pulse_s;
  logic [CODE_LEN-1:0] code_q;

  // Synchronise the raw prog button and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_sync_q <= 3'b000;
    end else begin
      prog_sync_q <= {prog_sync_q[1:0], prog_in};
    end
  end

  assign prog_pulse_s  = prog_sync_q[1] & ~prog_sync_q[2];
  assign active_code_s = code_q;
`else
  assign active_code_s = CODE;
`endif

  // Synchronise both digit buttons and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      b0_sync_q <= 3'b000;
      b1_sync_q <= 3'b000;
    end else begin
      b0_sync_q <= {b0_sync_q[1:0], b0_in};
      b1_sync_q <= {b1_sync_q[1:0], b1_in};
    end
  end

  // Decode press pulses; simultaneous pulses on both buttons are discarded.
  always_comb begin
    b0_pulse_s = b0_sync_q[1] & ~b0_sync_q[2];
    b1_pulse_s = b1_sync_q[1] & ~b1_sync_q[2];
    press_s    = b0_pulse_s ^ b1_pulse_s;
    digit_s    = b1_pulse_s;
  end

  // Lock state machine with registered status flags and saturating timers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fail_q       <= '0;
      gap_q        <= '0;
      open_q       <= '0;
      lock_q       <= '0;
      entry_q      <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
`ifdef SEQ_LOCK_PROG_EN
      code_q       <= CODE;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          unlocked_q   <= 1'b0;
          locked_out_q <= 1'b0;
          gap_q        <= '0;
          open_q       <= '0;
          lock_q       <= '0;
          if (press_s) begin
            entry_q <= shift_in(entry_q, digit_s);
            cnt_q   <= CNT_W'(1);
            state_q <= S_ENTRY;
          end else begin
            cnt_q   <= '0;
          end
        end

        S_ENTRY: begin
          unlocked_q   <= 1'b0;
          locked_out_q <= 1'b0;
          if (cnt_q == CNT_FULL) begin
            cnt_q <= '0;
            gap_q <= '0;
            if (entry_q == active_code_s) begin
              fail_q     <= '0;
              open_q     <= '0;
              unlocked_q <= 1'b1;
              state_q    <= S_OPEN;
            end else begin
              if (fail_q != FAIL_MAX) begin
                fail_q <= fail_q + FAIL_W'(1);
              end
              if (fail_q == FAIL_LAST) begin
                lock_q       <= '0;
                locked_out_q <= 1'b1;
                state_q      <= S_LOCKOUT;
              end else begin
                state_q      <= S_IDLE;
              end
            end
          end else if (press_s) begin
            entry_q <= shift_in(entry_q, digit_s);
            cnt_q   <= cnt_q + CNT_W'(1);
            gap_q   <= '0;
          end else if (gap_q == GAP_LAST) begin
            // Attempt abandoned: failure count is deliberately left untouched.
            cnt_q   <= '0;
            gap_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            gap_q   <= gap_q + GAP_W'(1);
          end
        end

        S_OPEN: begin
          locked_out_q <= 1'b0;
`ifdef SEQ_LOCK_PROG_EN
          if (prog_pulse_s) begin
            cnt_q      <= '0;
            gap_q      <= '0;
            open_q     <= '0;
            unlocked_q <= 1'b0;
            state_q    <= S_PROG;
          end else
`endif
          if (press_s || (open_q == OPEN_LAST)) begin
            // A relocking press is consumed here and never becomes a digit.
            open_q     <= '0;
            unlocked_q <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            open_q     <= open_q + OPEN_W'(1);
            unlocked_q <= 1'b1;
          end
        end

        S_LOCKOUT: begin
          unlocked_q <= 1'b0;
          if (lock_q == LOCK_LAST) begin
            lock_q       <= '0;
            fail_q       <= '0;
            locked_out_q <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            lock_q       <= lock_q + LOCK_W'(1);
            locked_out_q <= 1'b1;
          end
        end

`ifdef SEQ_LOCK_PROG_EN
        S_PROG: begin
          unlocked_q   <= 1'b0;
          locked_out_q <= 1'b0;
          if (cnt_q == CNT_FULL) begin
            code_q  <= entry_q;
            cnt_q   <= '0;
            gap_q   <= '0;
            state_q <= S_IDLE;
          end else if (press_s) begin
            entry_q <= shift_in(entry_q, digit_s);
            cnt_q   <= cnt_q + CNT_W'(1);
            gap_q   <= '0;
          end else if (gap_q == GAP_LAST) begin
            cnt_q   <= '0;
            gap_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            gap_q   <= gap_q + GAP_W'(1);
          end
        end
`endif

        default: begin
          cnt_q        <= '0;
          gap_q        <= '0;
          open_q       <= '0;
          lock_q       <= '0;
          unlocked_q   <= 1'b0;
          locked_out_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign unlocked   = unlocked_q;
  assign locked_out = locked_out_q;
  assign state_o    = state_q;
  assign progress   = 5'(cnt_q);
  assign fail_cnt   = 4'(fail_q);

endmodule

// File: tb/tb_seq_lock.sv
// Directed bench for seq_lock with default parameters.
// Define SEQ_LOCK_PROG_EN for both files to also exercise code programming.
module tb_seq_lock;

  logic       clk;
  logic       reset;
  logic       b0_in;
  logic       b1_in;
`ifdef SEQ_LOCK_PROG_EN
  logic       prog_in;
`endif
  logic       unlocked;
  logic       locked_out;
  logic [2:0] state_o;
  logic [4:0] progress;
  logic [3:0] fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  seq_lock dut (
    .clk        (clk),
    .reset      (reset),
    .b0_in      (b0_in),
    .b1_in      (b1_in),
`ifdef SEQ_LOCK_PROG_EN
    .prog_in    (prog_in),
`endif
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .state_o    (state_o),
    .progress   (progress),
    .fail_cnt   (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overall time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic d);
    if (d) b1_in = 1'b1;
    else   b0_in = 1'b1;
    step(4);
    b0_in = 1'b0;
    b1_in = 1'b0;
    step(4);
  endtask

  task automatic enter(input logic [4:0] c);
    for (int i = 4; i >= 0; i--) press(c[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    reset = 1'b1;
    b0_in = 1'b0;
    b1_in = 1'b0;
`ifdef SEQ_LOCK_PROG_EN
    prog_in = 1'b0;
`endif
    @(negedge clk);
    do_reset();
    check("rst_state",    32'(state_o),    32'd0);
    check("rst_progress", 32'(progress),   32'd0);
    check("rst_fail",     32'(fail_cnt),   32'd0);
    check("rst_unlocked", 32'(unlocked),   32'd0);
    check("rst_lockout",  32'(locked_out), 32'd0);

    // Correct code opens the lock.
    press(1'b0); press(1'b1); press(1'b0);
    check("entry_progress3", 32'(progress), 32'd3);
    check("entry_state",     32'(state_o),  32'd1);
    press(1'b1); press(1'b1);
    check("open_unlocked", 32'(unlocked), 32'd1);
    check("open_state",    32'(state_o),  32'd2);
    check("open_fail",     32'(fail_cnt), 32'd0);
    check("open_progress", 32'(progress), 32'd0);

    // Auto relock after 500 cycles (open entered 4 cycles before here).
    step(490);
    check("open_before_relock", 32'(unlocked), 32'd1);
    step(10);
    check("relock_unlocked", 32'(unlocked), 32'd0);
    check("relock_state",    32'(state_o),  32'd0);

    // Inter-press timeout (last press accepted 5 cycles before here).
    press(1'b0); press(1'b1); press(1'b0);
    step(190);
    check("gap_before_timeout_state", 32'(state_o),  32'd1);
    check("gap_before_timeout_prog",  32'(progress), 32'd3);
    step(10);
    check("timeout_state",    32'(state_o),  32'd0);
    check("timeout_progress", 32'(progress), 32'd0);
    check("timeout_fail",     32'(fail_cnt), 32'd0);

    // Simultaneous presses are discarded.
    b0_in = 1'b1; b1_in = 1'b1;
    step(4);
    b0_in = 1'b0; b1_in = 1'b0;
    step(4);
    check("both_progress", 32'(progress), 32'd0);
    check("both_state",    32'(state_o),  32'd0);

    // A long hold is one press only.
    b0_in = 1'b1;
    step(50);
    check("hold_progress", 32'(progress), 32'd1);
    b0_in = 1'b0;
    step(4);
    check("hold_state", 32'(state_o), 32'd1);
    press(1'b1); press(1'b0); press(1'b1); press(1'b1);
    check("hold_then_unlock", 32'(unlocked), 32'd1);

    // Press while open relocks and is not counted.
    press(1'b1);
    check("press_relock_state",    32'(state_o),  32'd0);
    check("press_relock_unlocked", 32'(unlocked), 32'd0);
    check("press_relock_progress", 32'(progress), 32'd0);

    // Three wrong attempts lead to lockout.
    enter(5'b11111);
    check("fail1_cnt",   32'(fail_cnt), 32'd1);
    check("fail1_state", 32'(state_o),  32'd0);
    enter(5'b11111);
    check("fail2_cnt", 32'(fail_cnt), 32'd2);
    enter(5'b11111);
    check("fail3_cnt",     32'(fail_cnt),   32'd3);
    check("fail3_state",   32'(state_o),    32'd3);
    check("fail3_lockout", 32'(locked_out), 32'd1);
    press(1'b0);
    check("lockout_press_state",    32'(state_o),  32'd3);
    check("lockout_press_progress", 32'(progress), 32'd0);
    check("lockout_press_fail",     32'(fail_cnt), 32'd3);
    step(978);
    check("lockout_late", 32'(locked_out), 32'd1);
    step(20);
    check("lockout_end_state", 32'(state_o),    32'd0);
    check("lockout_end_fail",  32'(fail_cnt),   32'd0);
    check("lockout_end_flag",  32'(locked_out), 32'd0);

    // Reset in the middle of an attempt.
    press(1'b0); press(1'b1); press(1'b0);
    check("pre_reset_progress", 32'(progress), 32'd3);
    do_reset();
    check("mid_reset_progress", 32'(progress), 32'd0);
    check("mid_reset_state",    32'(state_o),  32'd0);
    enter(5'b01011);
    check("post_reset_unlock", 32'(unlocked), 32'd1);
    do_reset();
    check("open_reset_state",    32'(state_o),  32'd0);
    check("open_reset_unlocked", 32'(unlocked), 32'd0);

`ifdef SEQ_LOCK_PROG_EN
    // Reprogram the code while open.
    enter(5'b01011);
    check("prog_open", 32'(state_o), 32'd2);
    prog_in = 1'b1;
    step(4);
    prog_in = 1'b0;
    step(4);
    check("prog_state", 32'(state_o), 32'd4);
    enter(5'b11001);
    check("prog_done_state", 32'(state_o), 32'd0);
    enter(5'b01011);
    check("old_code_unlocked", 32'(unlocked), 32'd0);
    check("old_code_fail",     32'(fail_cnt), 32'd1);
    enter(5'b11001);
    check("new_code_unlocked", 32'(unlocked), 32'd1);
    check("new_code_fail",     32'(fail_cnt), 32'd0);
    do_reset();
    enter(5'b01011);
    check("reset_code_unlocked", 32'(unlocked), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
